mesh_to_spm_ctrl: RTL

Return path from the compute mesh to the scratchpad. Each egress PE pushes 36-bit packets into its own small FIFO. A round-robin arbiter drains those FIFOs into a single registered SPM write port, and a base/count address generator places a programmed number of words into consecutive SRAM addresses. In pid-packed mode, the block undoes the packet-ID packing applied on the SPM-to-mesh path and flags malformed packets.

---
 rtl/mesh_to_spm_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mesh_to_spm_ctrl.sv
// mesh_to_spm_ctrl: drains per-PE egress FIFOs round-robin into a registered SPM write port,
// placing word_count words at consecutive addresses and optionally unpacking packet IDs.
module mesh_to_spm_ctrl #(
   parameter int SRAM_WRD_SIZE = 32,
   parameter int FIFO_WIDTH    = 36,
   parameter int FIFO_DEPTH    = 2,
   parameter int NUM_EGRESS_PE = 2,
   parameter int PKT_ID_WIDTH  = 4,
   parameter int ADDR_WIDTH    = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDR_WIDTH-1:0]    base_addr,
   input  logic [ADDR_WIDTH:0]      word_count,
   input  logic                     pid_sel,
   output logic                     busy,
   output logic                     done,
   output logic                     format_err,
   input  logic [NUM_EGRESS_PE-1:0] egress_enqueue,
   input  logic [FIFO_WIDTH-1:0]    egress_wdata [NUM_EGRESS_PE],
   output logic [NUM_EGRESS_PE-1:0] egress_full,
   output logic                     spm_wvalid,
   input  logic                     spm_wready,
   output logic [ADDR_WIDTH-1:0]    spm_waddr,
   output logic [SRAM_WRD_SIZE-1:0] spm_wdata,
   output logic [PKT_ID_WIDTH-1:0]  spm_wid
);
   localparam int RW = NUM_EGRESS_PE > 1 ? $clog2(NUM_EGRESS_PE) : 1;
   localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state_q, state_d;
   logic [RW-1:0] rr_q, rr_d, gnt, idx;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, waddr_q, waddr_d;
   logic [ADDR_WIDTH:0] issue_q, issue_d, ack_q, ack_d;
   logic pid_q, pid_d, ferr_q, ferr_d, wvalid_q, wvalid_d;
   logic [SRAM_WRD_SIZE-1:0] wdata_q, wdata_d;
   logic [PKT_ID_WIDTH-1:0] wid_q, wid_d, pkt_id;
   logic [NUM_EGRESS_PE-1:0] nempty, pop;
   logic [NUM_EGRESS_PE-1:0][FIFO_WIDTH-1:0] head;
   logic [FIFO_WIDTH-1:0] pkt;
   logic deq, accept, any, ld, bad;

   for (genvar g = 0; g < NUM_EGRESS_PE; g++) begin : g_fifo
      logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
      logic [PW-1:0] wp_q, rp_q;
      logic [CW-1:0] cnt_q;
      logic push;
      assign egress_full[g] = cnt_q == CW'(FIFO_DEPTH);
      assign push = egress_enqueue[g] & ~egress_full[g];
      assign nempty[g] = cnt_q != '0;
      assign pop[g] = deq & (gnt == RW'(g));
      assign head[g] = mem_q[rp_q];
      always_ff @(posedge clk)
         if (push) mem_q[wp_q] <= egress_wdata[g];
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
         end else begin
            if (push) wp_q <= wp_q == PW'(FIFO_DEPTH - 1) ? '0 : wp_q + PW'(1);
            if (pop[g]) rp_q <= rp_q == PW'(FIFO_DEPTH - 1) ? '0 : rp_q + PW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop[g]);
         end
   end

   // lowest offset from rr wins, so scan offsets from the far end down
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int i = NUM_EGRESS_PE - 1; i >= 0; i--) begin
         idx = RW'((int'(rr_q) + i) % NUM_EGRESS_PE);
         if (nempty[idx]) gnt = idx;
      end
   end

   assign any    = |nempty;
   assign pkt    = head[gnt];
   assign pkt_id = pkt[FIFO_WIDTH-1 -: PKT_ID_WIDTH];
   assign bad    = pkt[31:28] != {4{pkt[27]}};
   assign accept = wvalid_q & spm_wready;
   assign deq    = state_q == RUN && issue_q != '0 && any && (!wvalid_q || spm_wready);
   assign ld     = state_q == IDLE && start;

   always_comb begin
      state_d  = state_q == IDLE ? (start ? (word_count == '0 ? DONE : RUN) : IDLE)
               : state_q == RUN ? (accept && ack_q == (ADDR_WIDTH+1)'(1) ? DONE : RUN) : IDLE;
      rr_d     = deq ? (gnt == RW'(NUM_EGRESS_PE - 1) ? '0 : gnt + RW'(1)) : rr_q;
      addr_d   = ld ? base_addr : deq ? addr_q + ADDR_WIDTH'(1) : addr_q;
      issue_d  = ld ? word_count : issue_q - (ADDR_WIDTH+1)'(deq);
      ack_d    = ld ? word_count : ack_q - (ADDR_WIDTH+1)'(accept);
      pid_d    = ld ? pid_sel : pid_q;
      ferr_d   = ld ? 1'b0 : ferr_q | (deq & pid_q & bad);
      wvalid_d = deq | (wvalid_q & ~spm_wready);
      waddr_d  = deq ? addr_q : waddr_q;
      wid_d    = deq ? pkt_id : wid_q;
      wdata_d  = deq ? (pid_q ? {pkt_id, pkt[27:0]} : pkt[SRAM_WRD_SIZE-1:0]) : wdata_q;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q  <= IDLE;
         rr_q     <= '0;
         addr_q   <= '0;
         issue_q  <= '0;
         ack_q    <= '0;
         pid_q    <= 1'b0;
         ferr_q   <= 1'b0;
         wvalid_q <= 1'b0;
         waddr_q  <= '0;
         wid_q    <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         addr_q   <= addr_d;
         issue_q  <= issue_d;
         ack_q    <= ack_d;
         pid_q    <= pid_d;
         ferr_q   <= ferr_d;
         wvalid_q <= wvalid_d;
         waddr_q  <= waddr_d;
         wid_q    <= wid_d;
         wdata_q  <= wdata_d;
      end

   assign busy       = state_q == RUN;
   assign done       = state_q == DONE;
   assign format_err = ferr_q;
   assign spm_wvalid = wvalid_q;
   assign spm_waddr  = waddr_q;
   assign spm_wdata  = wdata_q;
   assign spm_wid    = wid_q;
endmodule
